// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared LED shifter state encoding and default geometry
package led_ctrl_pkg;

  // Default panel geometry, also consumed by the hps_io register map
  localparam int DEF_NB_LED_BAND = 20;
  localparam int DEF_WORD_BITS   = 48;
  localparam int DEF_NB_WORDS    = 16;
  localparam int DEF_SCLK_HALF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SCLK_LO,
    ST_SCLK_HI,
    ST_DONE
  } led_state_e;

  // Counter width for a count range of 'range' values, never below one bit
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/sclk_div.sv
// rtl/sclk_div.sv - restartable SCLK half-period tick generator
module sclk_div
  import led_ctrl_pkg::*;
#(
  parameter int SCLK_HALF = DEF_SCLK_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int              CW   = cnt_width(SCLK_HALF);
  localparam logic [CW-1:0]   TERM = CW'(SCLK_HALF - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick on the last cycle of each half-period so the caller can change phase
  assign tick = en && (cnt_q == TERM);

  // Count enabled cycles; a tick or restart returns the count to zero
  always_comb begin
    cnt_d = cnt_q;
    if (restart || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Half-period counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_shift_ctrl.sv
// rtl/led_shift_ctrl.sv - LED driver column shifter; optional stall counter under LED_SHIFT_CTRL_UNDERRUN_CNT_EN
module led_shift_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NB_LED_BAND = DEF_NB_LED_BAND,
  parameter int WORD_BITS   = DEF_WORD_BITS,
  parameter int NB_WORDS    = DEF_NB_WORDS,
  parameter int SCLK_HALF   = DEF_SCLK_HALF
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   start_column,
  input  logic [NB_LED_BAND-1:0] bit_data,
  input  logic                   bit_valid,
  output logic                   bit_ready,
  input  logic                   hps_override,
  input  logic [NB_LED_BAND-1:0] hps_SOUT,
  input  logic                   hps_LAT,
  input  logic                   hps_SCLK,
  output logic [NB_LED_BAND-1:0] SOUT,
  output logic                   LAT,
  output logic                   SCLK,
  output logic                   busy,
  output logic                   column_done,
  output logic                   underrun
`ifdef LED_SHIFT_CTRL_UNDERRUN_CNT_EN
  ,
  output logic [15:0]            underrun_cnt
`endif
);

  localparam int            BW        = cnt_width(WORD_BITS);
  localparam int            WW        = cnt_width(NB_WORDS);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(NB_WORDS - 1);

  led_state_e             state_q, state_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]          word_cnt_q, word_cnt_d;
  logic [NB_LED_BAND-1:0] sout_q, sout_d;
  logic                   lat_q, lat_d;
  logic                   sclk_q, sclk_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic                   underrun_q, underrun_d;

  logic                   in_clk_phase;
  logic                   tick;
  logic                   last_bit;
  logic                   last_word;
  logic                   lat_bit;
  logic                   xfer;

  assign in_clk_phase = (state_q == ST_SCLK_LO) || (state_q == ST_SCLK_HI);
  assign last_bit     = (bit_cnt_q == BIT_LAST);
  assign last_word    = (word_cnt_q == WORD_LAST);
  assign xfer         = bit_valid && ready_q;

  // Latch on the last bit of every word, and on the last three bits of the
  // final word so the drivers commit the whole column
  assign lat_bit = last_word ? ((int'(bit_cnt_q) + 3) >= WORD_BITS) : last_bit;

  sclk_div #(
    .SCLK_HALF(SCLK_HALF)
  ) u_sclk_div (
    .clk    (clk),
    .rst    (rst_in),
    .restart(!in_clk_phase),
    .en     (in_clk_phase),
    .tick   (tick)
  );

  // Next-state, counter and registered-output logic for the column FSM
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sout_d     = sout_q;
    underrun_d = underrun_q;

    case (state_q)
      ST_IDLE: begin
        if (start_column && !hps_override) begin
          state_d    = ST_FETCH;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          underrun_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (xfer) begin
          sout_d  = bit_data;
          state_d = ST_SCLK_LO;
        end else begin
          underrun_d = 1'b1;
        end
      end
      ST_SCLK_LO: begin
        if (tick) begin
          state_d = ST_SCLK_HI;
        end
      end
      ST_SCLK_HI: begin
        if (tick) begin
          if (last_bit && last_word) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            if (last_bit) begin
              bit_cnt_d  = '0;
              word_cnt_d = word_cnt_q + 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Counters only move on entry to FETCH, so lat_bit is stable for LO/HI
    sclk_d  = (state_d == ST_SCLK_HI);
    lat_d   = ((state_d == ST_SCLK_LO) || (state_d == ST_SCLK_HI)) && lat_bit;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_FETCH);
  end

  // FSM state, counters and glitch-free registered driver outputs
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sout_q     <= '0;
      lat_q      <= 1'b0;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sout_q     <= sout_d;
      lat_q      <= lat_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef LED_SHIFT_CTRL_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Count every FETCH cycle without data, saturating at all-ones
  always_comb begin
    ucnt_d = ucnt_q;
    if ((state_q == ST_FETCH) && !bit_valid && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

  // Software bit-bang path takes the pins without disturbing the FSM
  assign SOUT        = hps_override ? hps_SOUT : sout_q;
  assign LAT         = hps_override ? hps_LAT  : lat_q;
  assign SCLK        = hps_override ? hps_SCLK : sclk_q;
  assign busy        = busy_q;
  assign column_done = done_q;
  assign bit_ready   = ready_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// tb/tb_led_shift_ctrl.sv - self-checking bench for led_shift_ctrl (4-bit words, 2 words, SCLK_HALF 1)
module tb_led_shift_ctrl;

  localparam int NB = 20;
  localparam int WB = 4;
  localparam int NW = 2;
  localparam int SH = 1;

  typedef struct {
    logic [NB-1:0] sout;
    logic          lat;
  } exp_t;

  typedef struct {
    int   stall_at;
    int   stall_len;
    int   extra_start;
    int   ovr_from;
    int   exp_done;
    logic exp_ur;
    bit   chk_rises;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_column = 1'b0;
  logic [NB-1:0] bit_data = '0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic          hps_override = 1'b0;
  logic [NB-1:0] hps_SOUT = '0;
  logic          hps_LAT = 1'b0;
  logic          hps_SCLK = 1'b0;
  logic [NB-1:0] SOUT;
  logic          LAT;
  logic          SCLK;
  logic          busy;
  logic          column_done;
  logic          underrun;
`ifdef LED_SHIFT_CTRL_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [7:0] lat_mask;
  vec_t tbl[7];

  always #5 clk = ~clk;

  led_shift_ctrl #(
    .NB_LED_BAND(NB),
    .WORD_BITS  (WB),
    .NB_WORDS   (NW),
    .SCLK_HALF  (SH)
  ) dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .start_column(start_column),
    .bit_data    (bit_data),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .hps_override(hps_override),
    .hps_SOUT    (hps_SOUT),
    .hps_LAT     (hps_LAT),
    .hps_SCLK    (hps_SCLK),
    .SOUT        (SOUT),
    .LAT         (LAT),
    .SCLK        (SCLK),
    .busy        (busy),
    .column_done (column_done),
    .underrun    (underrun)
`ifdef LED_SHIFT_CTRL_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sout"}, 32'(SOUT), 32'd0);
    chk({tag, "_lat"}, 32'(LAT), 32'd0);
    chk({tag, "_sclk"}, 32'(SCLK), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(column_done), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    chk({tag, "_ready"}, 32'(bit_ready), 32'd0);
  endtask

  // One full column: drives the handshake, scoreboards SOUT/LAT at each SCLK edge
  task automatic run_column(input vec_t v, input string tag);
    int   cyc;
    int   fetch_idx;
    int   stall_left;
    int   rises;
    int   dones;
    int   done_cyc;
    int   limit;
    logic prev_sclk;
    logic ovr;
    logic [NB-1:0] data;
    exp_t e;
    exp_t last;
    sb.delete();
    cyc = 0; fetch_idx = 0; stall_left = v.stall_len; rises = 0; dones = 0;
    done_cyc = -1; limit = v.exp_done + 10;
    last.sout = '0; last.lat = 1'b0;
    @(negedge clk);
    start_column = 1'b1;
    bit_valid = 1'b0;
    prev_sclk = SCLK;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      start_column = (cyc == v.extra_start);
      ovr = (v.ovr_from >= 0) && (cyc >= v.ovr_from);
      if (ovr) begin
        hps_override = 1'b1;
        hps_SOUT = 20'hA5A5A ^ NB'(cyc);
        hps_LAT = 1'b1;
        hps_SCLK = cyc[0];
        #1;
        chk({tag, "_ovr_sout"}, 32'(SOUT), 32'(20'hA5A5A ^ NB'(cyc)));
        chk({tag, "_ovr_lat"}, 32'(LAT), 32'd1);
        chk({tag, "_ovr_sclk"}, 32'(SCLK), 32'(cyc[0]));
      end
      if (column_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (cyc == 1) chk({tag, "_busy_early"}, 32'(busy), 32'd1);
      if (!ovr) begin
        if (SCLK && !prev_sclk) begin
          rises++;
          if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            last = e;
            chk({tag, "_sout_rise"}, 32'(SOUT), 32'(e.sout));
            chk({tag, "_lat_rise"}, 32'(LAT), 32'(e.lat));
          end
        end
        if (!SCLK && prev_sclk) begin
          chk({tag, "_sout_fall"}, 32'(SOUT), 32'(last.sout));
        end
      end
      prev_sclk = SCLK;
      if (bit_ready) begin
        if ((fetch_idx == v.stall_at) && (stall_left > 0)) begin
          bit_valid = 1'b0;
          stall_left--;
        end else begin
          data = NB'($urandom);
          bit_valid = 1'b1;
          bit_data = data;
          e.sout = data;
          e.lat = (fetch_idx < 8) ? lat_mask[fetch_idx] : 1'b0;
          sb.push_back(e);
          fetch_idx++;
        end
      end else begin
        bit_valid = 1'b0;
      end
    end
    hps_override = 1'b0;
    hps_LAT = 1'b0;
    hps_SCLK = 1'b0;
    start_column = 1'b0;
    bit_valid = 1'b0;
    chk({tag, "_done_count"}, 32'(dones), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
    chk({tag, "_underrun"}, 32'(underrun), 32'(v.exp_ur));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    if (v.chk_rises) begin
      chk({tag, "_rises"}, 32'(rises), 32'(WB * NW));
      chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    end
  endtask

  initial begin
    int dones;
    lat_mask = 8'hE8;
    //           stall_at stall_len extra_start ovr_from exp_done ur  rises
    tbl[0] = '{-1, 0, -1, -1, 25, 1'b0, 1'b1};
    tbl[1] = '{ 2, 5, -1, -1, 30, 1'b1, 1'b1};
    tbl[2] = '{-1, 0, 12, -1, 25, 1'b0, 1'b1};
    tbl[3] = '{ 0, 1, -1, -1, 26, 1'b1, 1'b1};
    tbl[4] = '{ 7, 3, 28, -1, 28, 1'b1, 1'b1};
    tbl[5] = '{-1, 0, -1, 10, 25, 1'b0, 1'b0};
    tbl[6] = '{-1, 0, 25, -1, 25, 1'b0, 1'b1};

    @(negedge clk);
    chk_all_zero("reset");
`ifdef LED_SHIFT_CTRL_UNDERRUN_CNT_EN
    chk("reset_ucnt", 32'(underrun_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_column(tbl[i], $sformatf("col%0d", i));
    end

    // Override while idle must block a start request
    @(negedge clk);
    hps_override = 1'b1;
    start_column = 1'b1;
    @(negedge clk);
    start_column = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovr_idle_busy", 32'(busy), 32'd0);
    chk("ovr_idle_ready", 32'(bit_ready), 32'd0);
    hps_override = 1'b0;
    @(negedge clk);

    // Reset at word 1 bit 2 (global bit 6, a latch bit) aborts the column
    start_column = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_column = 1'b0;
      bit_valid = 1'b1;
      bit_data = NB'($urandom);
    end
    chk("pre_rst_lat", 32'(LAT), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_in = 1'b1;
    bit_valid = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (column_done) dones++;
    end
    chk("rst_no_done", 32'(dones), 32'd0);
    run_column(tbl[0], "after_rst");

`ifdef LED_SHIFT_CTRL_UNDERRUN_CNT_EN
    run_column('{1, 70000, -1, -1, 70025, 1'b1, 1'b1}, "long_stall");
    chk("ucnt_sat", 32'(underrun_cnt), 32'h0000FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
